// File: rtl/jpeg_enc_pkg.sv
// jpeg_enc_pkg: shared widths, code length type and flush FSM states for the JPEG entropy back end
package jpeg_enc_pkg;
  localparam int DEF_PIC_PIX_IN_WIDTH = 32;
  localparam int DEF_CODE_MAX_LEN = 27;
  typedef logic [4:0] code_len_t;
  typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_LAST} flush_state_t;
endpackage

// File: rtl/huffman_bit_pack.sv
// huffman_bit_pack: packs MSB-first variable-length codes into spaced 32-bit big-endian words with end-of-scan flush
module huffman_bit_pack
  import jpeg_enc_pkg::*;
#(
  parameter int PIC_PIX_IN_WIDTH = DEF_PIC_PIX_IN_WIDTH,
  parameter int CODE_MAX_LEN = DEF_CODE_MAX_LEN,
  parameter int ACC_WIDTH = 64,
  parameter int OUT_MIN_GAP = 3
) (
  input  logic                        clk_x8_i,
  input  logic                        rst_n_i,
  input  logic [CODE_MAX_LEN-1:0]     code_i,
  input  code_len_t                   code_len_i,
  input  logic                        code_valid_i,
  output logic                        code_ready_o,
  input  logic                        flush_i,
  output logic [PIC_PIX_IN_WIDTH-1:0] pic_data_out_o,
  output logic                        pic_data_out_valid_o,
  output logic                        pic_data_out_last_o,
  output logic [2:0]                  pic_data_out_bytes_o,
  output logic                        flush_done_o
);
  localparam int LW = $clog2(ACC_WIDTH + 1);
  localparam int GW = $clog2(OUT_MIN_GAP + 1);
  localparam logic [LW-1:0] WORD = LW'(PIC_PIX_IN_WIDTH);
  localparam logic [LW-1:0] RDY_MAX = LW'(ACC_WIDTH - CODE_MAX_LEN);
  localparam code_len_t LEN_MAX = code_len_t'(CODE_MAX_LEN);
  flush_state_t state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_a, acc_nx, ins;
  logic [LW-1:0] level, lvl_a, level_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [CODE_MAX_LEN-1:0] abits;
  logic [2:0] pad;
  code_len_t alen;
  logic take, emit_full, emit_last, done;
  assign code_ready_o = state == S_RUN && level <= RDY_MAX;
  // Bits live MSB-aligned in acc; the padding one-bits reuse the code append path
  always_comb begin
    take = code_valid_i && code_ready_o;
    pad = 3'd0 - level[2:0];
    alen = state == S_PAD ? {2'b00, pad} : !take ? '0 : code_len_i > LEN_MAX ? LEN_MAX : code_len_i;
    abits = (state == S_PAD ? '1 : code_i) & ~({CODE_MAX_LEN{1'b1}} << alen);
    ins = ({abits, {(ACC_WIDTH-CODE_MAX_LEN){1'b0}}} << (LEN_MAX - alen)) >> level;
    acc_a = acc | ins;
    lvl_a = level + LW'(alen);
    emit_full = gap == '0 && (state == S_RUN ? level >= WORD : state == S_DRAIN && level > WORD);
    emit_last = state == S_LAST && gap == '0 && level != '0;
    done = state == S_LAST && (gap == '0 || level == '0);
    acc_nx = emit_last ? '0 : emit_full ? acc_a << PIC_PIX_IN_WIDTH : acc_a;
    level_nx = emit_last ? '0 : emit_full ? lvl_a - WORD : lvl_a;
    gap_nx = (emit_full || emit_last) ? GW'(OUT_MIN_GAP - 1) : gap - GW'(gap != '0);
    state_nx = state == S_RUN ? (flush_i ? S_PAD : S_RUN) :
               state == S_PAD ? S_DRAIN :
               state == S_DRAIN ? (level <= WORD ? S_LAST : S_DRAIN) :
               (done ? S_RUN : S_LAST);
  end
  always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_RUN;
      acc <= '0;
      level <= '0;
      gap <= '0;
      pic_data_out_o <= '0;
      pic_data_out_valid_o <= 1'b0;
      pic_data_out_last_o <= 1'b0;
      pic_data_out_bytes_o <= 3'd0;
      flush_done_o <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      level <= level_nx;
      gap <= gap_nx;
      if (emit_full || emit_last) pic_data_out_o <= acc[ACC_WIDTH-1 -: PIC_PIX_IN_WIDTH];
      pic_data_out_valid_o <= emit_full || emit_last;
      pic_data_out_last_o <= emit_last;
      pic_data_out_bytes_o <= emit_last ? level[5:3] : emit_full ? 3'd4 : 3'd0;
      flush_done_o <= done;
    end
  end
endmodule

// File: tb/tb_huffman_bit_pack.sv
// tb_huffman_bit_pack: scoreboard bench for huffman_bit_pack with directed vectors and a bit-level model for the random stream
module tb_huffman_bit_pack;
  import jpeg_enc_pkg::*;
  logic clk_x8_i = 1'b0;
  logic rst_n_i = 1'b1;
  logic [26:0] code_i = '0;
  code_len_t code_len_i = '0;
  logic code_valid_i = 1'b0;
  logic code_ready_o;
  logic flush_i = 1'b0;
  logic [31:0] pic_data_out_o;
  logic pic_data_out_valid_o, pic_data_out_last_o, flush_done_o;
  logic [2:0] pic_data_out_bytes_o;
  typedef struct packed {logic [31:0] d; logic l; logic [2:0] b;} exp_t;
  exp_t eq[$];
  bit dq[$];
  bit bq[$];
  int checks = 0, errors = 0, cyc = 0, last_v = -100, in_bits = 0, out_words = 0;
  bit rnd = 0, chk_rdy = 0;

  huffman_bit_pack dut (
    .clk_x8_i(clk_x8_i), .rst_n_i(rst_n_i), .code_i(code_i), .code_len_i(code_len_i),
    .code_valid_i(code_valid_i), .code_ready_o(code_ready_o), .flush_i(flush_i),
    .pic_data_out_o(pic_data_out_o), .pic_data_out_valid_o(pic_data_out_valid_o),
    .pic_data_out_last_o(pic_data_out_last_o), .pic_data_out_bytes_o(pic_data_out_bytes_o),
    .flush_done_o(flush_done_o)
  );

  always #5 clk_x8_i = ~clk_x8_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void push_word(input bit l);
    logic [31:0] w = '0;
    int n = 0;
    for (int j = 31; j >= 0 && bq.size() > 0; j--) begin
      w[j] = bq.pop_front();
      n++;
    end
    eq.push_back('{d: w, l: l, b: l ? 3'(n / 8) : 3'd4});
  endfunction

  // Reference model for the random phase: a plain FIFO of bits chunked into words
  always @(posedge clk_x8_i) begin
    cyc++;
    if (rst_n_i && rnd && code_valid_i && code_ready_o) begin
      in_bits += 27;
      for (int j = 26; j >= 0; j--) bq.push_back(code_i[j]);
      while (bq.size() >= 32) push_word(1'b0);
    end
  end

  always @(negedge clk_x8_i) begin
    if (!rst_n_i) last_v = -100;
    else begin
      if (pic_data_out_valid_o) begin
        checks++;
        if (cyc - last_v < 3) begin
          errors++;
          $display("FAIL gap actual %0d cycles required >= 3", cyc - last_v);
        end
        last_v = cyc;
        out_words++;
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual %h required none", pic_data_out_o);
        end else begin
          exp_t e;
          e = eq.pop_front();
          check("word", pic_data_out_o, e.d);
          check("last", 32'(pic_data_out_last_o), 32'(e.l));
          check("bytes", 32'(pic_data_out_bytes_o), 32'(e.b));
        end
      end
      if (flush_done_o) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual 1 required 0");
        end else check("done_with_last", 32'(pic_data_out_valid_o && pic_data_out_last_o), 32'(dq.pop_front()));
      end
      if (chk_rdy) check("ready_vs_level", 32'(code_ready_o), 32'((in_bits - 32 * out_words) <= 37));
    end
  end

  task automatic send(input int len, input logic [26:0] c, input bit fl);
    int n = 0;
    while (!code_ready_o && n < 200) begin
      @(negedge clk_x8_i);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual 0 required 1");
    end
    code_len_i = 5'(len);
    code_i = c;
    code_valid_i = 1'b1;
    flush_i = fl;
    @(negedge clk_x8_i);
    code_valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk_x8_i);
    flush_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((eq.size() != 0 || dq.size() != 0) && n < 300) begin
      @(negedge clk_x8_i);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual %0d words %0d dones pending required 0", eq.size(), dq.size());
    end
    @(negedge clk_x8_i);
  endtask

  initial begin
    #1 rst_n_i = 1'b0;
    #1;
    check("rst_valid", 32'(pic_data_out_valid_o), 0);
    check("rst_data", pic_data_out_o, 0);
    check("rst_last_bytes_done", {28'd0, pic_data_out_last_o, pic_data_out_bytes_o} | 32'(flush_done_o), 0);
    check("rst_ready", 32'(code_ready_o), 1);
    repeat (3) @(negedge clk_x8_i);
    rst_n_i = 1'b1;
    @(negedge clk_x8_i);
    // Three codes forming one word, one cycle after the last accept
    eq.push_back('{d: 32'h43FF1237, l: 1'b0, b: 3'd4});
    send(8, 27'h43, 0);
    send(8, 27'hFF, 0);
    send(16, 27'h1237, 0);
    check("t1_not_early", 32'(pic_data_out_valid_o), 0);
    @(negedge clk_x8_i);
    check("t1_latency", 32'(pic_data_out_valid_o), 1);
    wait_idle();
    eq.push_back('{d: 32'h12345678, l: 1'b0, b: 3'd4});
    eq.push_back('{d: 32'h9ABCDEF0, l: 1'b0, b: 3'd4});
    for (int i = 1; i <= 16; i++) send(4, 27'(i % 16), 0);
    wait_idle();
    // Partial flush: 010 padded with ones
    eq.push_back('{d: 32'h5F000000, l: 1'b1, b: 3'd1});
    dq.push_back(1'b1);
    send(3, 27'b010, 0);
    do_flush();
    wait_idle();
    check("t3_back_to_run", 32'(code_ready_o), 1);
    dq.push_back(1'b0);
    do_flush();
    wait_idle();
    eq.push_back('{d: 32'hABCD1234, l: 1'b1, b: 3'd4});
    dq.push_back(1'b1);
    send(16, 27'hABCD, 0);
    send(16, 27'h1234, 1);
    wait_idle();
    // Zero length, masking of upper bits and clamping of oversize length
    eq.push_back('{d: 32'h31579BDF, l: 1'b0, b: 3'd4});
    send(0, 27'h5A5A5A5, 0);
    send(4, 27'h7FFFFF3, 0);
    send(31, 27'h0ABCDEF, 0);
    send(1, 27'h1, 0);
    wait_idle();
    in_bits = 0;
    out_words = 0;
    bq.delete();
    rnd = 1;
    chk_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      code_valid_i = 1'b1;
      code_len_i = 5'd27;
      code_i = 27'($urandom);
      @(negedge clk_x8_i);
    end
    code_valid_i = 1'b0;
    chk_rdy = 0;
    for (int n = 0; n < 100 && (in_bits - 32 * out_words) >= 32; n++) @(negedge clk_x8_i);
    do_flush();
    while (bq.size() % 8 != 0) bq.push_back(1'b1);
    while (bq.size() > 32) push_word(1'b0);
    dq.push_back(bq.size() > 0);
    if (bq.size() > 0) push_word(1'b1);
    rnd = 0;
    wait_idle();
    // Reset while draining discards everything
    send(27, 27'h1234567, 0);
    send(27, 27'h7654321, 1);
    @(posedge clk_x8_i);
    #1 rst_n_i = 1'b0;
    #1;
    check("t6_rst_valid", 32'(pic_data_out_valid_o), 0);
    check("t6_rst_data", pic_data_out_o, 0);
    check("t6_rst_done", 32'(flush_done_o), 0);
    repeat (2) @(negedge clk_x8_i);
    rst_n_i = 1'b1;
    @(negedge clk_x8_i);
    check("t6_ready", 32'(code_ready_o), 1);
    eq.push_back('{d: 32'hAB000000, l: 1'b1, b: 3'd1});
    dq.push_back(1'b1);
    send(8, 27'hAB, 1);
    wait_idle();
    repeat (5) @(negedge clk_x8_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
